// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared widths and requester ids for the data-RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int RAM_AW = 6;
    localparam int RAM_DW = 16;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_RD  = 1'b1
    } req_id_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick2
// Purpose  : Combinational 2-way winner picker. RAM_ARB_ROUND_ROBIN_EN selects
//            preferred-id tie breaking; otherwise the readout engine wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick2
    import ram_arb_pkg::*;
(
    input  logic    i_elig_cpu,
    input  logic    i_elig_rd,
    input  req_id_t i_pref,
    output logic    o_valid,
    output req_id_t o_winner
);

    req_id_t w_tie_winner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    assign w_tie_winner = i_pref;
`else
    logic w_unused_pref;
    assign w_unused_pref = (i_pref == REQ_RD);
    assign w_tie_winner  = REQ_RD;
`endif

    always_comb begin
        o_valid  = i_elig_cpu | i_elig_rd;
        o_winner = REQ_CPU;
        if (i_elig_cpu && i_elig_rd) begin
            o_winner = w_tie_winner;
        end else if (i_elig_rd) begin
            o_winner = REQ_RD;
        end
    end

endmodule : arb_pick2
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Registered request/grant arbiter sharing the single-port data RAM
//            between the CPU and the readout engine. Macro RAM_ARB_ROUND_ROBIN_EN
//            enables round-robin; default build is fixed readout-first priority.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          rd_req,
    input  logic          rd_we,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_wdata,
    output logic          rd_gnt,
    output logic          rd_rvalid,
    output logic [DW-1:0] rd_rdata,
    output logic          rd_stall,
    input  logic          rd_lock,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic          r_cpu_gnt;
    logic          r_rd_gnt;
    logic          r_cpu_rvalid;
    logic          r_rd_rvalid;
    logic          r_ram_en;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    req_id_t       r_owner;
    logic          r_rd_flag;

    logic          w_elig_cpu;
    logic          w_elig_rd;
    logic          w_win_valid;
    req_id_t       w_winner;
    req_id_t       w_pref;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // A requester granted this cycle sits out one arbitration so its held
    // request is not issued twice.
    assign w_elig_cpu = cpu_req & ~r_cpu_gnt & ~rd_lock;
    assign w_elig_rd  = rd_req  & ~r_rd_gnt;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    req_id_t r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= REQ_CPU;
        end else if (w_win_valid) begin
            r_ptr <= (w_winner == REQ_CPU) ? REQ_RD : REQ_CPU;
        end
    end

    assign w_pref = r_ptr;
`else
    assign w_pref = REQ_CPU;
`endif

    arb_pick2 u_pick (
        .i_elig_cpu (w_elig_cpu),
        .i_elig_rd  (w_elig_rd),
        .i_pref     (w_pref),
        .o_valid    (w_win_valid),
        .o_winner   (w_winner)
    );

    always_comb begin
        w_sel_we    = cpu_we;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
        if (w_winner == REQ_RD) begin
            w_sel_we    = rd_we;
            w_sel_addr  = rd_addr;
            w_sel_wdata = rd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_gnt    <= 1'b0;
            r_rd_gnt     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_rd_rvalid  <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_owner      <= REQ_CPU;
            r_rd_flag    <= 1'b0;
        end else begin
            r_cpu_gnt    <= w_win_valid & (w_winner == REQ_CPU);
            r_rd_gnt     <= w_win_valid & (w_winner == REQ_RD);
            r_ram_en     <= w_win_valid;
            r_ram_we     <= w_win_valid & w_sel_we;
            // The RAM returns data the cycle after the command; tag it to the owner.
            r_cpu_rvalid <= r_ram_en & r_rd_flag & (r_owner == REQ_CPU);
            r_rd_rvalid  <= r_ram_en & r_rd_flag & (r_owner == REQ_RD);
            if (w_win_valid) begin
                r_ram_addr <= w_sel_addr;
                r_ram_din  <= w_sel_wdata;
                r_owner    <= w_winner;
                r_rd_flag  <= ~w_sel_we;
            end
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign rd_gnt     = r_rd_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign rd_rvalid  = r_rd_rvalid;
    assign cpu_rdata  = ram_dout;
    assign rd_rdata   = ram_dout;
    assign cpu_stall  = cpu_req & ~r_cpu_gnt;
    assign rd_stall   = rd_req  & ~r_rd_gnt;
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_din    = r_ram_din;

endmodule : ram_port_arbiter
`default_nettype wire
